// File: rtl/project_select_ctrl.sv
// Wishbone-controlled project selector. Drives a registered one-hot (or zero)
// enable vector. Every change of selection first passes through an
// all-inactive guard interval, so two projects never share the io buses in
// the same cycle.
module project_select_ctrl #(
    parameter int          NUM_PROJECTS = 32,
    parameter int          GUARD_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] active,
    output logic        switching,
    output logic        switch_irq
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [31:0] NUM_LIMIT  = 32'(NUM_PROJECTS);

    state_t      state;
    state_t      next_state;

    logic        req_en;
    logic [4:0]  req_sel;
    logic        cur_en;
    logic [4:0]  cur_sel;
    logic [7:0]  guard_cnt;
    logic [15:0] sw_count;

    logic        hit;
    logic        accept;
    logic [5:0]  word;
    logic        ctrl_wr;
    logic        count_wr;
    logic        req_differs;
    logic        complete;
    logic        next_cur_en;
    logic [4:0]  next_cur_sel;
    logic [31:0] next_active;
    logic [31:0] rd_data;
    logic        unused_bits;

    // A transfer is taken on the first cycle of a strobe inside the window;
    // the registered ack masks the following cycle.
    assign hit         = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign accept      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
    assign word        = wbs_adr_i[7:2];
    assign ctrl_wr     = accept & wbs_we_i & (word == 6'd0);
    assign count_wr    = accept & wbs_we_i & (word == 6'd2);
    assign req_differs = (req_en != cur_en) || (req_sel != cur_sel);
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:13], wbs_dat_i[7:1]};

    // Read mux over the register map
    always_comb begin
        rd_data = 32'd0;
        case (word)
            6'd0:    rd_data = {19'd0, req_sel, 7'd0, req_en};
            6'd1:    rd_data = {15'd0, cur_en, 3'd0, cur_sel, 7'd0, switching};
            6'd2:    rd_data = {16'd0, sw_count};
            default: rd_data = 32'd0;
        endcase
    end

    // Bus handshake: one-cycle ack, read data presented alongside it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i) ? rd_data : 32'd0;
        end
    end

    // Requested selection, written byte-lane-wise through CTRL
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_en  <= 1'b0;
            req_sel <= 5'd0;
        end else if (ctrl_wr) begin
            if (wbs_sel_i[0]) req_en  <= wbs_dat_i[0];
            if (wbs_sel_i[1]) req_sel <= wbs_dat_i[12:8];
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= RUN;
        else          state <= next_state;
    end

    // FSM next state; a CTRL write during the drain restarts the guard, so it
    // takes priority over completion
    always_comb begin
        next_state = state;
        complete   = 1'b0;
        case (state)
            RUN: begin
                if (req_differs) next_state = DRAIN;
            end
            DRAIN: begin
                if (!ctrl_wr && guard_cnt == 8'd1) begin
                    next_state = RUN;
                    complete   = 1'b1;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // FSM outputs; the enable vector is computed from the next state so the
    // registered copy changes on the same edge as the state
    always_comb begin
        switching    = (state == DRAIN);
        next_cur_en  = complete ? req_en  : cur_en;
        next_cur_sel = complete ? req_sel : cur_sel;
        next_active  = 32'd0;
        if (next_state == RUN && next_cur_en && ({27'd0, next_cur_sel} < NUM_LIMIT))
            next_active = 32'd1 << next_cur_sel;
    end

    // Guard counter: loaded on drain entry and on every CTRL write while draining
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            guard_cnt <= 8'd0;
        end else if (state == RUN) begin
            if (req_differs) guard_cnt <= GUARD_LOAD;
        end else if (ctrl_wr) begin
            guard_cnt <= GUARD_LOAD;
        end else begin
            guard_cnt <= guard_cnt - 8'd1;
        end
    end

    // Current selection, registered enable vector and completion pulse
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cur_en     <= 1'b0;
            cur_sel    <= 5'd0;
            active     <= 32'd0;
            switch_irq <= 1'b0;
        end else begin
            cur_en     <= next_cur_en;
            cur_sel    <= next_cur_sel;
            active     <= next_active;
            switch_irq <= complete;
        end
    end

    // Completed-switch counter; a write clears it even on a completion edge
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                             sw_count <= 16'd0;
        else if (count_wr)                        sw_count <= 16'd0;
        else if (complete && sw_count != 16'hFFFF) sw_count <= sw_count + 16'd1;
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: two instances (32 projects / 16-cycle guard
// and 6 projects / 4-cycle guard) share one Wishbone bus. A deadline-based
// reference model predicts bus responses, enables and interrupts.
module tb_project_select_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;

    logic        ack_o    [2];
    logic [31:0] dat_o    [2];
    logic [31:0] active_o [2];
    logic        sw_o     [2];
    logic        irq_o    [2];

    project_select_ctrl #(.NUM_PROJECTS(32), .GUARD_CYCLES(16), .BASE_ADDR(BASE)) u0 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(ack_o[0]),
        .wbs_dat_o(dat_o[0]), .active(active_o[0]), .switching(sw_o[0]),
        .switch_irq(irq_o[0]));

    project_select_ctrl #(.NUM_PROJECTS(6), .GUARD_CYCLES(4), .BASE_ADDR(BASE)) u1 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(ack_o[1]),
        .wbs_dat_o(dat_o[1]), .active(active_o[1]), .switching(sw_o[1]),
        .switch_irq(irq_o[1]));

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic int np(input int i);
        return (i == 0) ? 32 : 6;
    endfunction

    function automatic int gc(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    // ---------------- reference model ----------------
    int          edge_no = 0;
    logic        m_ack;
    logic        m_req_en  [2];
    logic [4:0]  m_req_sel [2];
    logic        m_cur_en  [2];
    logic [4:0]  m_cur_sel [2];
    logic        m_drain   [2];
    int          m_deadline[2];
    logic        m_irq     [2];
    int          m_cnt     [2];
    logic [32:0] rdq0[$];
    logic [32:0] rdq1[$];

    logic        m_hit, m_acc, m_wr_ctrl, m_wr_cnt;
    logic [5:0]  m_off;
    assign m_hit     = (wbs_adr_i[31:8] == BASE[31:8]);
    assign m_acc     = wbs_cyc_i & wbs_stb_i & m_hit & !m_ack;
    assign m_off     = wbs_adr_i[7:2];
    assign m_wr_ctrl = m_acc & wbs_we_i & (m_off == 6'd0);
    assign m_wr_cnt  = m_acc & wbs_we_i & (m_off == 6'd2);

    function automatic logic [31:0] read_val(input int i, input logic [5:0] off);
        case (off)
            6'd0:    return (32'(m_req_sel[i]) << 8) | 32'(m_req_en[i]);
            6'd1:    return (32'(m_cur_en[i]) << 16) | (32'(m_cur_sel[i]) << 8) | 32'(m_drain[i]);
            6'd2:    return 32'(m_cnt[i]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic completes(input int i);
        return m_drain[i] && !m_wr_ctrl && (edge_no == m_deadline[i]);
    endfunction

    function automatic logic [31:0] exp_active(input int i);
        if (m_drain[i] || !m_cur_en[i] || int'(m_cur_sel[i]) >= np(i)) return 32'd0;
        return 32'd1 << m_cur_sel[i];
    endfunction

    always @(posedge wb_clk_i) begin
        edge_no <= edge_no + 1;
        if (wb_rst_i) begin
            m_ack <= 1'b0;
            rdq0.delete();
            rdq1.delete();
            for (int i = 0; i < 2; i++) begin
                m_req_en[i]   <= 1'b0;
                m_req_sel[i]  <= 5'd0;
                m_cur_en[i]   <= 1'b0;
                m_cur_sel[i]  <= 5'd0;
                m_drain[i]    <= 1'b0;
                m_deadline[i] <= 0;
                m_irq[i]      <= 1'b0;
                m_cnt[i]      <= 0;
            end
        end else begin
            m_ack <= m_acc;
            if (m_acc) begin
                rdq0.push_back({~wbs_we_i, read_val(0, m_off)});
                rdq1.push_back({~wbs_we_i, read_val(1, m_off)});
            end
            for (int i = 0; i < 2; i++) begin
                m_irq[i] <= completes(i);
                if (m_wr_ctrl) begin
                    if (wbs_sel_i[0]) m_req_en[i]  <= wbs_dat_i[0];
                    if (wbs_sel_i[1]) m_req_sel[i] <= wbs_dat_i[12:8];
                end
                if (m_drain[i]) begin
                    if (m_wr_ctrl) begin
                        m_deadline[i] <= edge_no + gc(i);
                    end else if (completes(i)) begin
                        m_drain[i]   <= 1'b0;
                        m_cur_en[i]  <= m_req_en[i];
                        m_cur_sel[i] <= m_req_sel[i];
                    end
                end else if (m_req_en[i] != m_cur_en[i] || m_req_sel[i] != m_cur_sel[i]) begin
                    m_drain[i]    <= 1'b1;
                    m_deadline[i] <= edge_no + gc(i);
                end
                if (m_wr_cnt)                          m_cnt[i] <= 0;
                else if (completes(i) && m_cnt[i] < 65535) m_cnt[i] <= m_cnt[i] + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   num_checks = 0;
    int   num_errors = 0;
    logic fin_req = 1'b0;
    logic fin_done = 1'b0;

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s inst%0d at edge %0d: got %h expected %h", nm, i, edge_no, act, exp);
        end
    endtask

    task automatic pop_check(input int i);
        logic [32:0] e;
        int          sz;
        sz = (i == 0) ? rdq0.size() : rdq1.size();
        if (sz == 0) begin
            check("unexpected_ack", i, 32'd1, 32'd0);
        end else begin
            e = (i == 0) ? rdq0.pop_front() : rdq1.pop_front();
            if (e[32]) check("rdata", i, dat_o[i], e[31:0]);
        end
    endtask

    always @(negedge wb_clk_i) begin
        for (int i = 0; i < 2; i++) begin
            check("active",    i, active_o[i], exp_active(i));
            check("onehot",    i, 32'($countones(active_o[i]) <= 1), 32'd1);
            check("switching", i, 32'(sw_o[i]), 32'(m_drain[i]));
            check("irq",       i, 32'(irq_o[i]), 32'(m_irq[i]));
            check("ack",       i, 32'(ack_o[i]), 32'(m_ack));
            if (ack_o[i] === 1'b1) pop_check(i);
        end
        if (fin_req && !fin_done) begin
            check("rdq_empty", 0, 32'(rdq0.size()), 32'd0);
            check("rdq_empty", 1, 32'(rdq1.size()), 32'd0);
            fin_done <= 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input int hold);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        repeat (hold) @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] dat);
        bus(1'b1, BASE + 32'(off), sel, dat, 1);
    endtask

    task automatic rd(input logic [7:0] off, input int hold);
        bus(1'b0, BASE + 32'(off), 4'hF, 32'd0, hold);
    endtask

    task automatic reset_pulse();
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        idle(3);
        wb_rst_i = 1'b0;
        idle(1);

        // Reset state and window decode
        rd(8'h04, 1);
        idle(2);
        bus(1'b0, BASE + 32'h100, 4'hF, 32'd0, 3);
        idle(2);

        // First selection, then count readback
        wr(8'h00, 4'hF, 32'h0000_0401);
        idle(22);
        rd(8'h08, 1);
        rd(8'h04, 1);

        // Switch 4 -> 5, then a same-value write
        wr(8'h00, 4'hF, 32'h0000_0501);
        idle(22);
        wr(8'h00, 4'hF, 32'h0000_0501);
        idle(22);
        rd(8'h04, 1);

        // Rewrite in the middle of a drain
        wr(8'h00, 4'hF, 32'h0000_0401);
        idle(7);
        wr(8'h00, 4'hF, 32'h0000_0701);
        idle(22);
        rd(8'h04, 1);

        // Lane-0-only write disables without touching SEL
        wr(8'h00, 4'h1, 32'h0000_0300);
        idle(22);
        rd(8'h04, 1);
        rd(8'h00, 1);

        // Out-of-range selection on the 6-project instance
        wr(8'h00, 4'hF, 32'h0000_0901);
        idle(22);
        rd(8'h04, 1);
        rd(8'h00, 3);

        // Counter clear, and clear landing on a completion edge
        wr(8'h08, 4'hF, 32'd0);
        rd(8'h08, 1);
        wr(8'h00, 4'hF, 32'h0000_0A01);
        idle(16);
        wr(8'h08, 4'hF, 32'd0);
        idle(5);
        rd(8'h08, 1);
        rd(8'h0C, 1);

        // Reset in the middle of a drain
        wr(8'h00, 4'hF, 32'h0000_0C01);
        idle(5);
        reset_pulse();
        idle(2);
        rd(8'h04, 1);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 3) begin
                wr(8'h00, 4'($urandom_range(0, 15)), $urandom);
            end else if (op <= 6) begin
                rd(8'(4 * $urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 3 : 1);
            end else if (op == 7) begin
                wr(8'h08, 4'($urandom_range(0, 15)), $urandom);
            end else if (op == 8) begin
                idle($urandom_range(0, 20));
            end else if (op == 9) begin
                bus($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? (BASE + 32'h104) : 32'h2000_0004,
                    4'hF, $urandom, 2);
            end else if (op == 10) begin
                if ($urandom_range(0, 7) == 0) reset_pulse();
                else idle(1);
            end else begin
                wr(8'(4 * $urandom_range(3, 8)), 4'hF, $urandom);
            end
        end

        idle(25);
        rd(8'h08, 1);
        rd(8'h04, 1);
        idle(3);
        fin_req = 1'b1;
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
